// File: rtl/add_operand_sequencer.sv
// Operand sequencer for an external combinational 16-bit adder: latches operands,
// waits SETTLE_CYCLES, captures the result and holds it until consumed.
// Optional `ADDSEQ_OVF_EN adds an out_ovf signed-overflow flag captured with the sum.
module add_operand_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_cin,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_cout,
  output logic [7:0]  op_count
`ifdef ADDSEQ_OVF_EN
  ,
  output logic        out_ovf
`endif
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                              (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic        add_cin_q, add_cin_d;
  logic [15:0] out_sum_q, out_sum_d;
  logic        out_cout_q, out_cout_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [7:0]  op_count_q, op_count_d;
`ifdef ADDSEQ_OVF_EN
  logic        out_ovf_q, out_ovf_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    op_count_d = op_count_q;
`ifdef ADDSEQ_OVF_EN
    out_ovf_d  = out_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          add_a_d   = in_a;
          add_b_d   = in_b;
          add_cin_d = in_cin;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        // The adder has seen stable operands for SETTLE_EFF cycles when the count hits zero.
        if (cnt_q == 4'd0) begin
          out_sum_d  = add_sum;
          out_cout_d = add_cout;
`ifdef ADDSEQ_OVF_EN
          out_ovf_d  = (add_a_q[15] == add_b_q[15]) && (add_sum[15] != add_a_q[15]);
`endif
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (out_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      add_a_q     <= 16'd0;
      add_b_q     <= 16'd0;
      add_cin_q   <= 1'b0;
      out_sum_q   <= 16'd0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count_q  <= 8'd0;
`ifdef ADDSEQ_OVF_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      op_count_q  <= op_count_d;
`ifdef ADDSEQ_OVF_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign op_count  = op_count_q;
`ifdef ADDSEQ_OVF_EN
  assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Scoreboard bench for add_operand_sequencer with a behavioural adder on the add_* side.
module tb_add_operand_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0, in_b = 16'd0;
  logic        in_cin = 1'b0;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic [7:0]  op_count;
`ifdef ADDSEQ_OVF_EN
  logic        out_ovf;
`endif

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_count = 8'd0;

  always #5 clk = ~clk;

  // External combinational adder the sequencer drives
  logic [16:0] add_res;
  assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign add_sum  = add_res[15:0];
  assign add_cout = add_res[16];

  add_operand_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .op_count(op_count)
`ifdef ADDSEQ_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold);
    exp_t        e;
    logic [16:0] full;
    int          lat;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk);
    full   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    chk("add_a", {16'd0, add_a}, {16'd0, a});
    chk("add_b", {16'd0, add_b}, {16'd0, b});
    chk("add_cin", {31'd0, add_cin}, {31'd0, cin});
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, SETTLE);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("out_sum", {16'd0, out_sum}, {16'd0, e.sum});
    chk("out_cout", {31'd0, out_cout}, {31'd0, e.cout});
`ifdef ADDSEQ_OVF_EN
    chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
`endif
    // Hold in RESP with a competing request that must be ignored
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = ~a; in_b = b ^ 16'h5a5a; in_cin = ~cin;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {16'd0, out_sum}, {16'd0, e.sum});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_add_a", {16'd0, add_a}, {16'd0, a});
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    chk("exit_valid", {31'd0, out_valid}, 32'd0);
    chk("exit_ready", {31'd0, in_ready}, 32'd1);
    chk("op_count", {24'd0, op_count}, {24'd0, exp_count});
    $display("TXN a=%04h b=%04h cin=%0d sum=%04h cout=%0d count=%0d",
             a, b, cin, out_sum, out_cout, op_count);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_add_a", {16'd0, add_a}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_txn(16'h1234, 16'h4321, 1'b0, 0);
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0);
    run_txn(16'h00FF, 16'h0000, 1'b1, 0);
    run_txn(16'hA5A5, 16'h5A5A, 1'b1, 5);

    // Reset during SETTLE discards the transaction
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_count = 8'd0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_add_a", {16'd0, add_a}, 32'd0);
    chk("mid_rst_add_b", {16'd0, add_b}, 32'd0);
    chk("mid_rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("mid_rst_op_count", {24'd0, op_count}, {24'd0, exp_count});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    end

    // 256 back-to-back transactions wrap op_count back to 0
    for (int n = 0; n < 256; n++) begin
      run_txn(16'($urandom), 16'($urandom), 1'($urandom), 0);
    end
    chk("wrap_op_count", {24'd0, op_count}, 32'd0);

`ifdef ADDSEQ_OVF_EN
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
